// File: rtl/pdp8_mem_model.sv
// PDP-8 main-memory model: self-initialising word array with a read-only fetch
// port, a read/write execute port and fixed-latency, fully pipelined reads.
module pdp8_mem_model #(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 12,
   parameter int DEPTH      = 4096,
   parameter int RD_LATENCY = 1,
   parameter int INIT_MODE  = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   output logic                  mem_ready,
   input  logic                  ifu_rd_req,
   input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
   output logic                  ifu_rd_valid,
   output logic [DATA_WIDTH-1:0] ifu_rd_data,
   input  logic                  exec_rd_req,
   input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
   output logic                  exec_rd_valid,
   output logic [DATA_WIDTH-1:0] exec_rd_data,
   input  logic                  exec_wr_req,
   input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
   input  logic [DATA_WIDTH-1:0] exec_wr_data,
   output logic                  addr_err
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [IW-1:0]       LAST_IDX = IW'(DEPTH - 1);

   typedef enum logic {INIT, READY} state_e;

   state_e                 state_q, state_d;
   logic [IW-1:0]          initCnt_q, initCnt_d;
   logic                   initWe;
   logic [DATA_WIDTH-1:0]  addrWord;
   logic [DATA_WIDTH-1:0]  initWord;

   logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

   logic                   memReady;
   logic                   ifuInRange, exRdInRange, wrInRange;
   logic                   ifuTake, exRdTake, wrTake, errSeen;
   logic [DATA_WIDTH-1:0]  ifuWord, exRdWord;

   logic [RD_LATENCY-1:0]                 ifuV_q, exRdV_q;
   logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] ifuD_q, exRdD_q;
   logic                                  addrErr_q, addrErr_d;

   // The mode-1 pattern is the word's own address, fitted to the data width.
   if (IW >= DATA_WIDTH) begin : g_trunc
      assign addrWord = initCnt_q[DATA_WIDTH-1:0];
   end else begin : g_ext
      assign addrWord = {{(DATA_WIDTH - IW){1'b0}}, initCnt_q};
   end

   always_comb begin
      case (INIT_MODE)
         0:       initWord = '0;
         2:       initWord = ~addrWord;
         default: initWord = addrWord;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      initCnt_d = initCnt_q;
      initWe    = 1'b0;
      case (state_q)
         INIT: begin
            initWe    = 1'b1;
            initCnt_d = initCnt_q + IW'(1);
            if (initCnt_q == LAST_IDX) begin
               state_d = READY;
            end
         end
         READY: begin
            state_d = READY;
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= INIT;
         initCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         initCnt_q <= initCnt_d;
      end
   end

   assign memReady    = (state_q == READY);
   assign ifuInRange  = ({1'b0, ifu_rd_addr}  < DEPTH_W);
   assign exRdInRange = ({1'b0, exec_rd_addr} < DEPTH_W);
   assign wrInRange   = ({1'b0, exec_wr_addr} < DEPTH_W);

   assign ifuTake  = memReady && ifu_rd_req;
   assign exRdTake = memReady && exec_rd_req;
   assign wrTake   = memReady && exec_wr_req && wrInRange;
   assign errSeen  = memReady && ((ifu_rd_req  && !ifuInRange)  ||
                                  (exec_rd_req && !exRdInRange) ||
                                  (exec_wr_req && !wrInRange));

   // Write-first: a same-edge write to the read address forwards its data.
   always_comb begin
      ifuWord  = '0;
      exRdWord = '0;
      if (ifuInRange) begin
         if (wrTake && (exec_wr_addr == ifu_rd_addr)) begin
            ifuWord = exec_wr_data;
         end else begin
            ifuWord = mem_q[ifu_rd_addr[IW-1:0]];
         end
      end
      if (exRdInRange) begin
         if (wrTake && (exec_wr_addr == exec_rd_addr)) begin
            exRdWord = exec_wr_data;
         end else begin
            exRdWord = mem_q[exec_rd_addr[IW-1:0]];
         end
      end
   end

   // The array carries no reset; the init sequencer fills it before any access.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         if (initWe) begin
            mem_q[initCnt_q] <= initWord;
         end else if (wrTake) begin
            mem_q[exec_wr_addr[IW-1:0]] <= exec_wr_data;
         end
      end
   end

   assign addrErr_d = addrErr_q | errSeen;

   // Data stages only load alongside a valid, so the last stage holds between pulses.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ifuV_q    <= '0;
         ifuD_q    <= '0;
         exRdV_q   <= '0;
         exRdD_q   <= '0;
         addrErr_q <= 1'b0;
      end else begin
         addrErr_q  <= addrErr_d;
         ifuV_q[0]  <= ifuTake;
         exRdV_q[0] <= exRdTake;
         if (ifuTake) begin
            ifuD_q[0] <= ifuWord;
         end
         if (exRdTake) begin
            exRdD_q[0] <= exRdWord;
         end
         for (int k = 1; k < RD_LATENCY; k++) begin
            ifuV_q[k]  <= ifuV_q[k-1];
            exRdV_q[k] <= exRdV_q[k-1];
            if (ifuV_q[k-1]) begin
               ifuD_q[k] <= ifuD_q[k-1];
            end
            if (exRdV_q[k-1]) begin
               exRdD_q[k] <= exRdD_q[k-1];
            end
         end
      end
   end

   assign mem_ready     = memReady;
   assign ifu_rd_valid  = ifuV_q[RD_LATENCY-1];
   assign ifu_rd_data   = ifuD_q[RD_LATENCY-1];
   assign exec_rd_valid = exRdV_q[RD_LATENCY-1];
   assign exec_rd_data  = exRdD_q[RD_LATENCY-1];
   assign addr_err      = addrErr_q;

endmodule

// File: doc/pdp8_mem_model.md
Name: pdp8_mem_model

Overview:
Parametrised PDP-8 main-memory behavioural model. It serves a read-only instruction-fetch port and a read/write execute port with fixed, configurable read latency and valid strobes. Contents are deterministically initialised by an internal sequencer after reset. It replaces the random-data fetch stub in unit and integration benches for the fetch and execute units.

Parameters:
DATA_WIDTH, 12, word width in bits.
ADDR_WIDTH, 12, address width in bits.
DEPTH, 4096, implemented words; legal range 1 to 2**ADDR_WIDTH.
RD_LATENCY, 1, cycles from request sample to valid; legal range 1..4.
INIT_MODE, 1, init pattern: 0 = all zero; 1 = address (zero-extended or truncated to DATA_WIDTH); 2 = bitwise complement of mode 1.

Ports:
clk  in  1  clock; all logic on rising edge.
reset_n  in  1  synchronous active-low reset.
mem_ready  out  1  high once initialisation is complete.
ifu_rd_req  in  1  fetch read request, sampled every edge.
ifu_rd_addr  in  ADDR_WIDTH  fetch address.
ifu_rd_valid  out  1  one-cycle pulse; ifu_rd_data is valid.
ifu_rd_data  out  DATA_WIDTH  fetch read data; holds between pulses.
exec_rd_req  in  1  execute read request.
exec_rd_addr  in  ADDR_WIDTH  execute read address.
exec_rd_valid  out  1  one-cycle pulse; exec_rd_data is valid.
exec_rd_data  out  DATA_WIDTH  execute read data; holds between pulses.
exec_wr_req  in  1  execute write request; completes in one cycle.
exec_wr_addr  in  ADDR_WIDTH  write address.
exec_wr_data  in  DATA_WIDTH  write data.
addr_err  out  1  sticky flag: out-of-range access seen.

Behaviour:
- Reset (reset_n low at an edge):
  - mem_ready = 0, both valids = 0, both data outputs = 0, addr_err = 0.
  - All read pipelines are flushed; in-flight reads never produce a valid.
  - FSM goes to INIT with the init counter = 0.
- FSM has two states, INIT and READY.
  - INIT: each cycle writes the pattern word to mem[counter], then increments the counter. After writing address DEPTH-1 it enters READY.
  - mem_ready rises on the edge that writes DEPTH-1, so it is high exactly DEPTH cycles after reset release.
  - READY persists until the next reset.
- Requests are level-sampled; there is no edge detection on req.
  - Requests (read or write) sampled while mem_ready = 0 are ignored: no valid, no write.
- Read latency: a request sampled at edge N produces valid high for the cycle following edge N+RD_LATENCY-1 (RD_LATENCY = 1: valid follows edge N).
  - Data is captured from the array at edge N.
  - Pipelines are fully pipelined, so one request per cycle per port yields one valid per cycle, in order.
- Write: mem[exec_wr_addr] is updated at the sampling edge.
- Same-edge write and read (either port) to the same address: the read returns the new data (write-first).
- Both read ports are independent and may target the same address in the same cycle; no arbitration or stall.
- Addresses >= DEPTH:
  - A read still produces valid at the normal latency with data 0.
  - A write is dropped.
  - addr_err is set and stays set until reset.
- Data outputs update only on valid cycles and hold their last value otherwise.
- No X is ever driven after the first reset edge.

Test Plan:
1. DEPTH=4096, INIT_MODE=1, RD_LATENCY=2; release reset. Required: mem_ready low for 4096 cycles, then high. ifu_rd_req to 0o0200 during INIT gives no ifu_rd_valid.
2. After ready, ifu_rd_req addr 0o0200 at edge N. Required: ifu_rd_valid pulses once, visible after edge N+1, with ifu_rd_data = 0o0200. Data holds 0o0200 afterwards.
3. Same edge: exec_wr 0o0300 <= 0o7402 and ifu_rd 0o0300. Required: ifu_rd_data = 0o7402 at valid. A later exec_rd of 0o0300 also returns 0o7402.
4. ifu reads 0o0000..0o0003 on four consecutive edges, with an exec_rd of 0o0010 in parallel. Required: four consecutive ifu valids with data 0,1,2,3, and one exec valid with data 0o0010.
5. DEPTH=2048: read 0o4000, then write 0o4000 <= 0o1234. Required: valid with data 0, addr_err = 1 and sticky, no aliasing into 0o0000 (reads 0o0000).
6. Read pending at RD_LATENCY=2 with reset_n asserted one cycle later, after a prior write of 0o7402 to 0o0300. Required: no valid emerges, mem_ready drops, addr_err clears, and 0o0300 reads 0o0300 after re-init.
